// File: rtl/link_scan_ctrl.sv
// Channel-select sequencer for the 8-channel serial mux/demux link: dwell-timed slots, masked-channel skip,
// one-shot or continuous frames. Define LINK_SCAN_MASK_EN to honour ch_mask; otherwise every channel is scanned.
module link_scan_ctrl #(
   parameter int NCH     = 8,
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [NCH-1:0]     ch_mask,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic               latch,
   output logic               frame_done,
   output logic               busy
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t             state_q;
   logic               start_q;
   logic [NCH-1:0]     mask_q;
   logic [SEL_W-1:0]   sel_q;
   logic [DWELL_W-1:0] cnt_q;
   logic               sel_valid_q, latch_q, frame_done_q, busy_q;

   logic [NCH-1:0]     eff_mask;
   logic               start_edge;
   logic [DWELL_W-1:0] dwell_ld;
   logic               dwell_one;
   logic [SEL_W-1:0]   first_ch, next_ch;
   logic               first_is_last, next_is_last, cur_is_last;

`ifdef LINK_SCAN_MASK_EN
   assign eff_mask = ch_mask;
`else
   logic unused_ch_mask;
   assign unused_ch_mask = ^ch_mask;
   assign eff_mask       = '1;
`endif

   function automatic logic [SEL_W-1:0] lowest_ch(input logic [NCH-1:0] m);
      lowest_ch = '0;
      for (int i = NCH - 1; i >= 0; i--)
         if (m[i]) lowest_ch = SEL_W'(i);
   endfunction

   function automatic logic [SEL_W-1:0] higher_ch(input logic [NCH-1:0] m, input logic [SEL_W-1:0] cur);
      higher_ch = cur;
      for (int i = NCH - 1; i >= 0; i--)
         if (m[i] && i > int'(cur)) higher_ch = SEL_W'(i);
   endfunction

   function automatic logic any_higher(input logic [NCH-1:0] m, input logic [SEL_W-1:0] cur);
      any_higher = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (m[i] && i > int'(cur)) any_higher = 1'b1;
   endfunction

   always_comb begin
      start_edge    = start & ~start_q;
      dwell_ld      = (dwell == '0) ? DWELL_W'(1) : dwell;
      dwell_one     = (dwell_ld == DWELL_W'(1));
      first_ch      = lowest_ch(eff_mask);
      first_is_last = !any_higher(eff_mask, first_ch);
      next_ch       = higher_ch(mask_q, sel_q);
      next_is_last  = !any_higher(mask_q, next_ch);
      cur_is_last   = !any_higher(mask_q, sel_q);
   end

   // latch/frame_done are registered, so each is set one cycle ahead: when the
   // cycle being entered is the final cycle of its slot (cnt_q will read 1).
   // NOTE: start_q resets to 1 so a start held high through reset release is not seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         start_q      <= 1'b1;
         mask_q       <= '0;
         sel_q        <= '0;
         cnt_q        <= '0;
         sel_valid_q  <= 1'b0;
         latch_q      <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         start_q <= start;
         case (state_q)
            IDLE: begin
               latch_q      <= 1'b0;
               frame_done_q <= 1'b0;
               if (start_edge && eff_mask != '0) begin
                  state_q      <= SCAN;
                  mask_q       <= eff_mask;
                  sel_q        <= first_ch;
                  cnt_q        <= dwell_ld;
                  sel_valid_q  <= 1'b1;
                  busy_q       <= 1'b1;
                  latch_q      <= dwell_one;
                  frame_done_q <= dwell_one && first_is_last;
               end
            end
            SCAN: begin
               if (cnt_q > DWELL_W'(1)) begin
                  cnt_q        <= cnt_q - DWELL_W'(1);
                  latch_q      <= (cnt_q == DWELL_W'(2));
                  frame_done_q <= (cnt_q == DWELL_W'(2)) && cur_is_last;
               end else if (cur_is_last && mode_cont && !stop && eff_mask != '0) begin
                  mask_q       <= eff_mask;
                  sel_q        <= first_ch;
                  cnt_q        <= dwell_ld;
                  latch_q      <= dwell_one;
                  frame_done_q <= dwell_one && first_is_last;
               end else if (cur_is_last || stop) begin
                  state_q      <= IDLE;
                  sel_valid_q  <= 1'b0;
                  busy_q       <= 1'b0;
                  latch_q      <= 1'b0;
                  frame_done_q <= 1'b0;
               end else begin
                  sel_q        <= next_ch;
                  cnt_q        <= dwell_ld;
                  latch_q      <= dwell_one;
                  frame_done_q <= dwell_one && next_is_last;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sel        = sel_q;
   assign sel_valid  = sel_valid_q;
   assign latch      = latch_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_link_scan_ctrl.sv
// Directed self-checking bench for link_scan_ctrl; follows LINK_SCAN_MASK_EN for mask expectations.
module tb_link_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, mode_cont;
   logic [7:0] dwell;
   logic [7:0] ch_mask;
   logic [2:0] sel;
   logic       sel_valid, latch, frame_done, busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   link_scan_ctrl #(.NCH(8), .SEL_W(3), .DWELL_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_cont(mode_cont),
      .dwell(dwell), .ch_mask(ch_mask), .sel(sel), .sel_valid(sel_valid),
      .latch(latch), .frame_done(frame_done), .busy(busy)
   );

   // Called at a negedge; leaves the bench at the negedge showing the first frame cycle.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Walks the slots listed in chs (ascending) for d cycles each, comparing every cycle.
   task automatic walk_frame(input string name, input logic [7:0] chs, input int d, input bit fd_end);
      int hi;
      hi = -1;
      for (int i = 0; i < 8; i++) if (chs[i]) hi = i;
      for (int ch = 0; ch < 8; ch++) begin
         if (chs[ch]) begin
            for (int k = 0; k < d; k++) begin
               logic [6:0] exp_v, got_v;
               exp_v = {3'(ch), 1'b1, 1'b1, (k == d - 1), (k == d - 1) && (ch == hi) && fd_end};
               got_v = {sel, sel_valid, busy, latch, frame_done};
               n_checks++;
               if (got_v !== exp_v) begin
                  n_errors++;
                  $display("FAIL %s ch%0d cyc%0d: got {sel,valid,busy,latch,fd}=%b expected %b",
                           name, ch, k, got_v, exp_v);
               end
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start     = 1'($urandom);
         stop      = 1'($urandom);
         mode_cont = 1'($urandom);
         dwell     = 8'($urandom);
         ch_mask   = 8'($urandom);
         @(negedge clk);
         n_checks++;
         if ({sel, sel_valid, latch, frame_done, busy} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_vals: got %b expected 0", {sel, sel_valid, latch, frame_done, busy});
         end
      end
      start = 1'b1; stop = 1'b0; mode_cont = 1'b0; dwell = 8'd2; ch_mask = 8'hFF;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || sel_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_start_held: got busy=%b valid=%b expected 0 0", busy, sel_valid);
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_oneshot();
      mode_cont = 1'b0; dwell = 8'd2; ch_mask = 8'hFF;
      pulse_start();
      walk_frame("oneshot", 8'hFF, 2, 1'b1);
      n_checks++;
      if ({sel, sel_valid, busy, latch, frame_done} !== {3'd7, 4'b0}) begin
         n_errors++;
         $display("FAIL oneshot_idle: got %b expected %b", {sel, sel_valid, busy, latch, frame_done}, {3'd7, 4'b0});
      end
   endtask

   task automatic test_mask_skip();
      logic [7:0] exp_chs;
`ifdef LINK_SCAN_MASK_EN
      exp_chs = 8'h25;
`else
      exp_chs = 8'hFF;
`endif
      mode_cont = 1'b0; dwell = 8'd1; ch_mask = 8'h25;
      pulse_start();
      ch_mask = 8'hFF;
      walk_frame("mask_skip", exp_chs, 1, 1'b1);
      n_checks++;
      if (busy !== 1'b0 || sel_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL mask_skip_idle: got busy=%b valid=%b expected 0 0", busy, sel_valid);
      end
   endtask

   task automatic test_cont_stop();
      mode_cont = 1'b1; dwell = 8'd3; ch_mask = 8'hFF;
      pulse_start();
      walk_frame("cont_stop_head", 8'h07, 3, 1'b0);
      n_checks++;
      if ({sel, latch} !== {3'd3, 1'b0}) begin
         n_errors++;
         $display("FAIL stop_slot3_c0: got sel=%0d latch=%b expected 3 0", sel, latch);
      end
      @(negedge clk);
      stop = 1'b1;
      n_checks++;
      if ({sel, latch} !== {3'd3, 1'b0}) begin
         n_errors++;
         $display("FAIL stop_slot3_c1: got sel=%0d latch=%b expected 3 0", sel, latch);
      end
      @(negedge clk);
      n_checks++;
      if ({sel, busy, latch, frame_done} !== {3'd3, 3'b110}) begin
         n_errors++;
         $display("FAIL stop_slot3_c2: got %b expected %b", {sel, busy, latch, frame_done}, {3'd3, 3'b110});
      end
      @(negedge clk);
      n_checks++;
      if ({sel, sel_valid, busy, latch, frame_done} !== {3'd3, 4'b0}) begin
         n_errors++;
         $display("FAIL stop_idle: got %b expected %b", {sel, sel_valid, busy, latch, frame_done}, {3'd3, 4'b0});
      end
      stop = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      mode_cont = 1'b1; dwell = 8'd1; ch_mask = 8'hFF;
      pulse_start();
      walk_frame("cont_frame1", 8'hFF, 1, 1'b1);
      mode_cont = 1'b0;
      walk_frame("cont_frame2", 8'hFF, 1, 1'b1);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL cont_end_idle: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_dwell0_mask0();
      logic [7:0] exp_chs;
`ifdef LINK_SCAN_MASK_EN
      exp_chs = 8'h03;
`else
      exp_chs = 8'hFF;
`endif
      mode_cont = 1'b0; dwell = 8'd0; ch_mask = 8'h03;
      pulse_start();
      walk_frame("dwell0", exp_chs, 1, 1'b1);
      ch_mask = 8'h00;
      pulse_start();
`ifdef LINK_SCAN_MASK_EN
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (busy !== 1'b0 || sel_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mask0_ignored cyc%0d: got busy=%b valid=%b expected 0 0", i, busy, sel_valid);
         end
         @(negedge clk);
      end
`else
      walk_frame("mask0_ignored_port", 8'hFF, 1, 1'b1);
`endif
   endtask

   task automatic test_async_reset();
      mode_cont = 1'b0; dwell = 8'd2; ch_mask = 8'hFF;
      pulse_start();
      walk_frame("pre_reset", 8'h0F, 2, 1'b0);
      n_checks++;
      if (sel !== 3'd4 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL pre_reset_sel: got sel=%0d busy=%b expected 4 1", sel, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({sel, sel_valid, latch, frame_done, busy} !== 7'b0) begin
         n_errors++;
         $display("FAIL async_reset: got %b expected 0", {sel, sel_valid, latch, frame_done, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      walk_frame("post_reset", 8'hFF, 2, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; dwell = 8'd1; ch_mask = 8'hFF;
      @(negedge clk);
      test_reset();
      test_oneshot();
      test_mask_skip();
      test_cont_stop();
      test_back_to_back();
      test_dwell0_mask0();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
